fp_mac_result_sink: RTL

- Receive end of the floating-point MAC result stream. AXI-Stream slave that accepts 32-bit IEEE-754 single-precision results.
- Buffers results in a first-word-fall-through (FWFT) FIFO and presents them to downstream logic through a simple pop interface.
- Sticky exception flags are decoded from each accepted word, plus a saturating count of accepted results.
- Sits between the MAC IP's m_axis_result port and the consumer, replacing the current tie-off where the result stream is left unthrottled and unobserved.

---
 rtl/fp_mac_result_sink.sv | 118 +++++++++++
 1 files changed

// File: rtl/fp_mac_result_sink.sv
// Receive end of the FP MAC result stream: AXI-Stream slave into a FWFT FIFO with a pop port,
// sticky IEEE-754 exception flags and a saturating accepted-word counter.
module fp_mac_result_sink #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_result_tvalid,
  output logic                     s_axis_result_tready,
  input  logic [31:0]              s_axis_result_tdata,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic                     clr_flags,
  output logic                     flag_nan,
  output logic                     flag_inf,
  output logic                     flag_zero,
  output logic                     flag_denorm,
  output logic [CNT_W-1:0]         accept_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]    DepthC = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             tready_q, tready_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [3:0]       flags_q, flags_d, dec;  // {nan, inf, zero, denorm}
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  logic             push, pop;
  logic [7:0]       exp_f;
  logic             man_nz;

  always_comb begin
    push = s_axis_result_tvalid && tready_q;
    pop  = rd_en && (count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    tready_d = (count_d != DepthC);

    // Registered head: the incoming word becomes the head only when nothing older remains.
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_d = s_axis_result_tdata;
      end else begin
        rd_data_d = mem_q[rd_ptr_d];
      end
    end

    exp_f  = s_axis_result_tdata[30:23];
    man_nz = |s_axis_result_tdata[22:0];
    dec    = {(exp_f == 8'hFF) && man_nz, (exp_f == 8'hFF) && !man_nz,
              (exp_f == 8'h00) && !man_nz, (exp_f == 8'h00) && man_nz};
    // Set beats clear for the same flag on the same edge.
    flags_d = (flags_q & {4{!clr_flags}}) | (push ? dec : 4'b0000);

    accept_cnt_d = accept_cnt_q;
    if (push && (accept_cnt_q != CntMax)) begin
      accept_cnt_d = accept_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_result_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tready_q     <= 1'b0;
      rd_data_q    <= '0;
      flags_q      <= '0;
      accept_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tready_q     <= tready_d;
      rd_data_q    <= rd_data_d;
      flags_q      <= flags_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign s_axis_result_tready = tready_q;
  assign count       = count_q;
  assign full        = (count_q == DepthC);
  assign empty       = (count_q == '0);
  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_data_q;
  assign flag_nan    = flags_q[3];
  assign flag_inf    = flags_q[2];
  assign flag_zero   = flags_q[1];
  assign flag_denorm = flags_q[0];
  assign accept_cnt  = accept_cnt_q;

endmodule
